// File: rtl/pc_redirect_unit_pkg.sv
// rtl/pc_redirect_unit_pkg.sv - shared types and defaults for the PC redirect unit
// Purpose: redirect priority encoding, FSM state constants and default parameters.
// Ports: none (package).
package pc_redirect_unit_pkg;

    // Numeric order is the arbitration order: a larger value wins.
    typedef enum logic [1:0] {
        NONE   = 2'd0,
        BRANCH = 2'd1,
        JUMP   = 2'd2,
        TRAP   = 2'd3
    } redir_prio_t;

    typedef logic [1:0] pc_state_t;

    localparam pc_state_t BOOT = 2'd0;
    localparam pc_state_t RUN  = 2'd1;
    localparam pc_state_t HOLD = 2'd2;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          DEFAULT_PC_INC   = 4;

endpackage

// File: rtl/pc_redirect_unit_if.sv
// rtl/pc_redirect_unit_if.sv - execute/fetch bundle for the PC redirect unit
// Purpose: groups redirect requests (from execute) and fetch-side PC outputs.
// Ports: fetch_ready, branch, zero, branch_target, jump, jump_target, trap,
//        trap_vector (into the unit); pc, pc_valid, flush, redirect_pending (out).
interface pc_redirect_unit_if #(
    parameter int XLEN = 32
);
    logic            fetch_ready;
    logic            branch;
    logic            zero;
    logic [XLEN-1:0] branch_target;
    logic            jump;
    logic [XLEN-1:0] jump_target;
    logic            trap;
    logic [XLEN-1:0] trap_vector;
    logic [XLEN-1:0] pc;
    logic            pc_valid;
    logic            flush;
    logic            redirect_pending;

    // Drives requests and consumes the PC (pipeline side).
    modport master (
        output fetch_ready, branch, zero, branch_target,
        output jump, jump_target, trap, trap_vector,
        input  pc, pc_valid, flush, redirect_pending
    );

    // The PC redirect unit itself.
    modport slave (
        input  fetch_ready, branch, zero, branch_target,
        input  jump, jump_target, trap, trap_vector,
        output pc, pc_valid, flush, redirect_pending
    );
endinterface

// File: rtl/pc_redirect_unit_redirect_arbiter.sv
// rtl/pc_redirect_unit_redirect_arbiter.sv - fixed-priority redirect source select
// Purpose: combinational trap > jump > taken-branch selection.
// Ports: branch_i, zero_i, branch_target_i, jump_i, jump_target_i, trap_i,
//        trap_vector_i (in); valid_o, prio_o, target_o (out).
module redirect_arbiter
    import pc_redirect_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            branch_i,
    input  logic            zero_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_target_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vector_i,
    output logic            valid_o,
    output redir_prio_t     prio_o,
    output logic [XLEN-1:0] target_o
);

    always_comb begin
        valid_o  = 1'b0;
        prio_o   = NONE;
        target_o = '0;
        if (trap_i) begin
            valid_o  = 1'b1;
            prio_o   = TRAP;
            target_o = trap_vector_i;
        end else if (jump_i) begin
            // JALR computes an arbitrary sum; the low bit is never a valid fetch address.
            valid_o  = 1'b1;
            prio_o   = JUMP;
            target_o = {jump_target_i[XLEN-1:1], 1'b0};
        end else if (branch_i && zero_i) begin
            // A branch only redirects when its condition resolved true.
            valid_o  = 1'b1;
            prio_o   = BRANCH;
            target_o = branch_target_i;
        end
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// rtl/pc_redirect_unit.sv - PC register with prioritised redirect and stall hold
// Purpose: owns the fetch PC; advances it sequentially, redirects on trap/jump/
//          taken branch, and parks a redirect while fetch is stalled.
// Ports: clk, rst_n (async active-low); bus (slave modport): redirect requests
//        in, pc/pc_valid/flush/redirect_pending out (all registered).
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
    parameter int              PC_INC   = DEFAULT_PC_INC
) (
    input  logic               clk,
    input  logic               rst_n,
    pc_redirect_unit_if.slave  bus
);

    logic            req_valid;
    redir_prio_t     req_prio;
    logic [XLEN-1:0] req_target;

    redirect_arbiter #(
        .XLEN (XLEN)
    ) u_arbiter (
        .branch_i        (bus.branch),
        .zero_i          (bus.zero),
        .branch_target_i (bus.branch_target),
        .jump_i          (bus.jump),
        .jump_target_i   (bus.jump_target),
        .trap_i          (bus.trap),
        .trap_vector_i   (bus.trap_vector),
        .valid_o         (req_valid),
        .prio_o          (req_prio),
        .target_o        (req_target)
    );

    pc_state_t       state_q,       state_d;
    logic [XLEN-1:0] pc_q,          pc_d;
    logic            pc_valid_q,    pc_valid_d;
    logic            flush_q,       flush_d;
    logic            pending_q,     pending_d;
    logic [XLEN-1:0] pend_target_q, pend_target_d;
    redir_prio_t     pend_prio_q,   pend_prio_d;

    // Equal priority overwrites so the youngest resolution of the same kind wins.
    logic take_new;
    assign take_new = req_valid && (req_prio >= pend_prio_q);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_valid_d    = pc_valid_q;
        flush_d       = 1'b0;
        pend_target_d = pend_target_q;
        pend_prio_d   = pend_prio_q;

        case (state_q)
            BOOT: begin
                // Redirects are ignored here: nothing has been fetched yet.
                pc_valid_d = 1'b1;
                state_d    = RUN;
            end
            RUN: begin
                if (bus.fetch_ready) begin
                    if (req_valid) begin
                        pc_d    = req_target;
                        flush_d = 1'b1;
                    end else begin
                        pc_d = pc_q + XLEN'(PC_INC);
                    end
                end else if (req_valid) begin
                    pend_target_d = req_target;
                    pend_prio_d   = req_prio;
                    flush_d       = 1'b1;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (bus.fetch_ready) begin
                    pc_d          = take_new ? req_target : pend_target_q;
                    flush_d       = take_new;
                    pend_target_d = '0;
                    pend_prio_d   = NONE;
                    state_d       = RUN;
                end else if (take_new) begin
                    pend_target_d = req_target;
                    pend_prio_d   = req_prio;
                    flush_d       = 1'b1;
                end
            end
            default: begin
                state_d    = BOOT;
                pc_valid_d = 1'b0;
            end
        endcase

        pending_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            pc_valid_q    <= 1'b0;
            flush_q       <= 1'b0;
            pending_q     <= 1'b0;
            pend_target_q <= '0;
            pend_prio_q   <= NONE;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_valid_q    <= pc_valid_d;
            flush_q       <= flush_d;
            pending_q     <= pending_d;
            pend_target_q <= pend_target_d;
            pend_prio_q   <= pend_prio_d;
        end
    end

    assign bus.pc               = pc_q;
    assign bus.pc_valid         = pc_valid_q;
    assign bus.flush            = flush_q;
    assign bus.redirect_pending = pending_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb/tb_pc_redirect_unit.sv - directed self-checking bench for pc_redirect_unit
module tb_pc_redirect_unit;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    pc_redirect_unit_if #(.XLEN(32)) bus();

    pc_redirect_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .PC_INC   (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.fetch_ready   = 1'b0;
        bus.branch        = 1'b0;
        bus.zero          = 1'b0;
        bus.branch_target = '0;
        bus.jump          = 1'b0;
        bus.jump_target   = '0;
        bus.trap          = 1'b0;
        bus.trap_vector   = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        n_cmp++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want %h", bus.pc, 32'h0); end
        n_cmp++; if (bus.pc_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.pc_valid); end
        n_cmp++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL rst_flush: got %b want 0", bus.flush); end
        n_cmp++; if (bus.redirect_pending !== 1'b0) begin n_fail++; $display("FAIL rst_pending: got %b want 0", bus.redirect_pending); end
        rst_n = 1'b1;
        bus.fetch_ready = 1'b1;
        #1;
        n_cmp++; if (bus.pc_valid !== 1'b0) begin n_fail++; $display("FAIL boot_valid: got %b want 0", bus.pc_valid); end
        tick();
        n_cmp++; if (bus.pc_valid !== 1'b1) begin n_fail++; $display("FAIL run_valid: got %b want 1", bus.pc_valid); end
        n_cmp++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL seq_pc0: got %h want %h", bus.pc, 32'h0); end
        tick();
        n_cmp++; if (bus.pc !== 32'h4) begin n_fail++; $display("FAIL seq_pc1: got %h want %h", bus.pc, 32'h4); end
        tick();
        n_cmp++; if (bus.pc !== 32'h8) begin n_fail++; $display("FAIL seq_pc2: got %h want %h", bus.pc, 32'h8); end
        tick();
        n_cmp++; if (bus.pc !== 32'hC) begin n_fail++; $display("FAIL seq_pc3: got %h want %h", bus.pc, 32'hC); end
        n_cmp++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL seq_flush: got %b want 0", bus.flush); end
        bus.fetch_ready = 1'b0;
        tick();
    endtask

    task automatic test_branch();
        bus.fetch_ready = 1'b1; bus.jump = 1'b1; bus.jump_target = 32'h100;
        tick();
        n_cmp++; if (bus.pc !== 32'h100) begin n_fail++; $display("FAIL setup_pc: got %h want %h", bus.pc, 32'h100); end
        bus.jump = 1'b0; bus.fetch_ready = 1'b0;
        tick();
        n_cmp++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL setup_flush_once: got %b want 0", bus.flush); end
        bus.fetch_ready = 1'b1; bus.branch = 1'b1; bus.zero = 1'b0; bus.branch_target = 32'h200;
        tick();
        n_cmp++; if (bus.pc !== 32'h104) begin n_fail++; $display("FAIL br_nt_pc: got %h want %h", bus.pc, 32'h104); end
        n_cmp++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL br_nt_flush: got %b want 0", bus.flush); end
        bus.zero = 1'b1;
        tick();
        n_cmp++; if (bus.pc !== 32'h200) begin n_fail++; $display("FAIL br_t_pc: got %h want %h", bus.pc, 32'h200); end
        n_cmp++; if (bus.flush !== 1'b1) begin n_fail++; $display("FAIL br_t_flush: got %b want 1", bus.flush); end
        bus.branch = 1'b0; bus.zero = 1'b0; bus.fetch_ready = 1'b0;
        tick();
        n_cmp++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL br_t_flush_end: got %b want 0", bus.flush); end
        n_cmp++; if (bus.pc !== 32'h200) begin n_fail++; $display("FAIL br_stall_pc: got %h want %h", bus.pc, 32'h200); end
    endtask

    task automatic test_hold_jump();
        bus.fetch_ready = 1'b0; bus.jump = 1'b1; bus.jump_target = 32'h301;
        tick();
        n_cmp++; if (bus.redirect_pending !== 1'b1) begin n_fail++; $display("FAIL hj_pending: got %b want 1", bus.redirect_pending); end
        n_cmp++; if (bus.pc !== 32'h200) begin n_fail++; $display("FAIL hj_pc_held: got %h want %h", bus.pc, 32'h200); end
        n_cmp++; if (bus.flush !== 1'b1) begin n_fail++; $display("FAIL hj_flush: got %b want 1", bus.flush); end
        bus.jump = 1'b0;
        tick();
        n_cmp++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL hj_flush_once: got %b want 0", bus.flush); end
        n_cmp++; if (bus.pc_valid !== 1'b1) begin n_fail++; $display("FAIL hj_valid: got %b want 1", bus.pc_valid); end
        tick();
        n_cmp++; if (bus.pc !== 32'h200) begin n_fail++; $display("FAIL hj_pc_held2: got %h want %h", bus.pc, 32'h200); end
        bus.fetch_ready = 1'b1;
        tick();
        n_cmp++; if (bus.pc !== 32'h300) begin n_fail++; $display("FAIL hj_apply_pc: got %h want %h", bus.pc, 32'h300); end
        n_cmp++; if (bus.redirect_pending !== 1'b0) begin n_fail++; $display("FAIL hj_pending_clr: got %b want 0", bus.redirect_pending); end
        n_cmp++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL hj_apply_flush: got %b want 0", bus.flush); end
        bus.fetch_ready = 1'b0;
        tick();
    endtask

    task automatic test_overwrite();
        bus.branch = 1'b1; bus.zero = 1'b1; bus.branch_target = 32'h400;
        tick();
        n_cmp++; if (bus.flush !== 1'b1) begin n_fail++; $display("FAIL ow_br_flush: got %b want 1", bus.flush); end
        bus.branch = 1'b0; bus.zero = 1'b0;
        tick();
        bus.trap = 1'b1; bus.trap_vector = 32'h80;
        tick();
        n_cmp++; if (bus.flush !== 1'b1) begin n_fail++; $display("FAIL ow_trap_flush: got %b want 1", bus.flush); end
        n_cmp++; if (bus.pc !== 32'h300) begin n_fail++; $display("FAIL ow_pc_held: got %h want %h", bus.pc, 32'h300); end
        bus.trap = 1'b0;
        tick();
        bus.branch = 1'b1; bus.zero = 1'b1; bus.branch_target = 32'h500;
        tick();
        n_cmp++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL ow_drop_flush: got %b want 0", bus.flush); end
        n_cmp++; if (bus.redirect_pending !== 1'b1) begin n_fail++; $display("FAIL ow_drop_pending: got %b want 1", bus.redirect_pending); end
        bus.branch = 1'b0; bus.zero = 1'b0; bus.fetch_ready = 1'b1;
        tick();
        n_cmp++; if (bus.pc !== 32'h80) begin n_fail++; $display("FAIL ow_apply_pc: got %h want %h", bus.pc, 32'h80); end
        n_cmp++; if (bus.redirect_pending !== 1'b0) begin n_fail++; $display("FAIL ow_pending_clr: got %b want 0", bus.redirect_pending); end
        bus.fetch_ready = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous();
        bus.fetch_ready = 1'b1;
        bus.trap = 1'b1; bus.trap_vector = 32'h1000;
        bus.jump = 1'b1; bus.jump_target = 32'h2001;
        bus.branch = 1'b1; bus.zero = 1'b1; bus.branch_target = 32'h3000;
        tick();
        n_cmp++; if (bus.pc !== 32'h1000) begin n_fail++; $display("FAIL sim_trap_pc: got %h want %h", bus.pc, 32'h1000); end
        n_cmp++; if (bus.flush !== 1'b1) begin n_fail++; $display("FAIL sim_trap_flush: got %b want 1", bus.flush); end
        bus.trap = 1'b0;
        tick();
        n_cmp++; if (bus.pc !== 32'h2000) begin n_fail++; $display("FAIL sim_jump_pc: got %h want %h", bus.pc, 32'h2000); end
        clear_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        bus.fetch_ready = 1'b1; bus.jump = 1'b1; bus.jump_target = 32'h40;
        tick();
        n_cmp++; if (bus.pc !== 32'h40) begin n_fail++; $display("FAIL b2b_pc0: got %h want %h", bus.pc, 32'h40); end
        bus.jump = 1'b0; bus.branch = 1'b1; bus.zero = 1'b1; bus.branch_target = 32'h50;
        tick();
        n_cmp++; if (bus.pc !== 32'h50) begin n_fail++; $display("FAIL b2b_pc1: got %h want %h", bus.pc, 32'h50); end
        n_cmp++; if (bus.flush !== 1'b1) begin n_fail++; $display("FAIL b2b_flush1: got %b want 1", bus.flush); end
        bus.branch = 1'b0; bus.zero = 1'b0;
        tick();
        n_cmp++; if (bus.pc !== 32'h54) begin n_fail++; $display("FAIL b2b_pc2: got %h want %h", bus.pc, 32'h54); end
        n_cmp++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL b2b_flush2: got %b want 0", bus.flush); end
        bus.fetch_ready = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        bus.fetch_ready = 1'b1; bus.jump = 1'b1; bus.jump_target = 32'hFFFF_FFFC;
        tick();
        n_cmp++; if (bus.pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_setup: got %h want %h", bus.pc, 32'hFFFF_FFFC); end
        bus.jump = 1'b0;
        tick();
        n_cmp++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h want %h", bus.pc, 32'h0); end
        bus.fetch_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_hold();
        bus.jump = 1'b1; bus.jump_target = 32'h700;
        tick();
        n_cmp++; if (bus.redirect_pending !== 1'b1) begin n_fail++; $display("FAIL rh_pending: got %b want 1", bus.redirect_pending); end
        bus.jump = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL rh_pc: got %h want %h", bus.pc, 32'h0); end
        n_cmp++; if (bus.redirect_pending !== 1'b0) begin n_fail++; $display("FAIL rh_pending_clr: got %b want 0", bus.redirect_pending); end
        n_cmp++; if (bus.pc_valid !== 1'b0) begin n_fail++; $display("FAIL rh_valid: got %b want 0", bus.pc_valid); end
        tick();
        rst_n = 1'b1;
        bus.fetch_ready = 1'b1;
        tick();
        n_cmp++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL rh_flush: got %b want 0", bus.flush); end
        n_cmp++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL rh_boot_pc: got %h want %h", bus.pc, 32'h0); end
        tick();
        n_cmp++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL rh_flush2: got %b want 0", bus.flush); end
        n_cmp++; if (bus.pc !== 32'h4) begin n_fail++; $display("FAIL rh_pc_adv: got %h want %h", bus.pc, 32'h4); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        clear_inputs();
        test_reset();
        test_branch();
        test_hold_jump();
        test_overwrite();
        test_simultaneous();
        test_back_to_back();
        test_wrap();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
